// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths, stall polarity and fetch FSM encoding for the instruction-fetch controller.
package if_fetch_ctrl_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned STALL_W     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [INST_W-1:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

  // A bus read is outstanding in these states; the request line follows it.
  function automatic logic bus_busy(input fetch_state_e s);
    return (s == S_REQ) || (s == S_DISCARD);
  endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one bus read per PC, stall request while waiting,
// hold buffer for stalled pipelines, flush discard and fetch timeout.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [INST_W-1:0] NOP_INST       = NOP_INST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  output logic                   ibus_req,
  output logic [INST_ADDR_W-1:0] ibus_addr,
  input  logic                   ibus_ack,
  input  logic [INST_W-1:0]      ibus_rdata,
  output logic [INST_W-1:0]      inst_o,
  output logic                   stallreq_if,
  output logic                   timeout_o
);

  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  fetch_state_e           r_state;
  fetch_state_e           w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [INST_W-1:0]      r_buf;
  logic [INST_ADDR_W-1:0] r_addr;
  logic                   r_timeout;
  logic                   w_expired;
  logic                   w_hold_ld;
  logic                   w_addr_ld;
  logic                   w_unused_stall;

  // Only the IF/ID hold bit matters to fetch; the rest of the vector is for later stages.
  assign w_unused_stall = ^{stall[STALL_W-1:2], stall[0]};

  assign w_expired = (r_cnt == CNT_MAX) && !ibus_ack;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a request is never withdrawn before its ack except on timeout or reset.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_ld   = 1'b0;
    w_addr_ld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ce && !flush) begin
          w_state_nxt = S_REQ;
          w_addr_ld   = 1'b1;
        end
      end
      S_REQ: begin
        if (ibus_ack) begin
          if (flush) begin
            w_state_nxt = S_IDLE;
          end else if (stall[1] == STOP) begin
            w_state_nxt = S_HOLD;
            w_hold_ld   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_expired) begin
          w_state_nxt = S_IDLE;
        end else if (flush || !ce) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_HOLD: begin
        if (flush || !ce || (stall[1] == NO_STOP)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (ibus_ack || w_expired) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pipeline-facing outputs; the ack/rdata paths are combinational so a zero-wait fetch costs no extra cycle.
  always_comb begin
    inst_o      = NOP_INST;
    stallreq_if = NO_STOP;
    case (r_state)
      S_IDLE: begin
        stallreq_if = ce;
      end
      S_REQ: begin
        stallreq_if = !ibus_ack;
        if (ibus_ack && !flush) begin
          inst_o = ibus_rdata;
        end
      end
      S_HOLD: begin
        inst_o = r_buf;
      end
      S_DISCARD: begin
        stallreq_if = STOP;
      end
      default: begin
        inst_o      = NOP_INST;
        stallreq_if = NO_STOP;
      end
    endcase
  end

  // Wait counter restarts whenever a bus-busy state is (re)entered.
  always_comb begin
    w_cnt_nxt = '0;
    if (bus_busy(w_state_nxt) && (w_state_nxt == r_state)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Address, hold buffer, wait counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= ZERO_WORD;
      r_buf     <= ZERO_WORD;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_addr_ld) begin
        r_addr <= pc;
      end
      if (w_hold_ld) begin
        r_buf <= ibus_rdata;
      end
      r_cnt     <= w_cnt_nxt;
      r_timeout <= (w_cnt_nxt == CNT_MAX);
    end
  end

  assign ibus_req  = bus_busy(r_state);
  assign ibus_addr = r_addr;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed and randomized checks of if_fetch_ctrl against a flag-based fetch model.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  localparam int unsigned       TMO = 8;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic [5:0]  stall;
  logic        flush;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic [31:0] inst_o;
  logic        stallreq_if;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  // Model: is a read on the bus, will its data be thrown away, is an instruction parked.
  bit          m_busy = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_held = 1'b0;
  bit          m_tmo  = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_buf  = '0;
  int          m_wait = 0;
  logic [31:0] e_inst;
  logic        e_stallreq = 1'b1;

  always #5 clk = ~clk;

  if_fetch_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .NOP_INST      (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .pc         (pc),
    .stall      (stall),
    .flush      (flush),
    .ibus_req   (ibus_req),
    .ibus_addr  (ibus_addr),
    .ibus_ack   (ibus_ack),
    .ibus_rdata (ibus_rdata),
    .inst_o     (inst_o),
    .stallreq_if(stallreq_if),
    .timeout_o  (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic predict();
    e_inst = NOP;
    if (m_busy && !m_drop && ibus_ack && !flush) e_inst = ibus_rdata;
    else if (m_held) e_inst = m_buf;
    if (m_busy) e_stallreq = m_drop || !ibus_ack;
    else if (m_held) e_stallreq = 1'b0;
    else e_stallreq = ce;
  endtask

  // Mid-cycle comparison of every output with the model.
  task automatic settle();
    @(negedge clk);
    predict();
    chk("m_req",   32'(ibus_req),    32'(m_busy));
    chk("m_addr",  ibus_addr,        m_addr);
    chk("m_inst",  inst_o,           e_inst);
    chk("m_stall", 32'(stallreq_if), 32'(e_stallreq));
    chk("m_tmo",   32'(timeout_o),   32'(m_tmo));
  endtask

  // Clock edge: advance model and the emulated pc_reg.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_drop = 0; m_held = 0; m_tmo = 0;
      m_buf = '0; m_addr = '0; m_wait = 0;
    end else begin
      m_tmo = 0;
      if (m_busy) begin
        if (ibus_ack) begin
          if (!m_drop && !flush && stall[1]) begin
            m_held = 1; m_buf = ibus_rdata;
          end
          m_busy = 0; m_drop = 0;
        end else if (m_wait == int'(TMO)) begin
          m_busy = 0; m_drop = 0;
        end else if (!m_drop && (flush || !ce)) begin
          m_drop = 1; m_wait = 0;
        end else begin
          m_wait++;
          m_tmo = (m_wait == int'(TMO));
        end
      end else if (m_held) begin
        if (flush || !ce || !stall[1]) m_held = 0;
      end else if (ce && !flush) begin
        m_busy = 1; m_addr = pc; m_wait = 0;
      end
      if (flush) pc = 32'h180;
      else if (!e_stallreq && !stall[0] && ce) pc = pc + 32'd4;
    end
    #1;
  endtask

  initial begin
    int cnt;
    rst = 1; ce = 0; pc = '0; stall = '0; flush = 0; ibus_ack = 0; ibus_rdata = '0;
    advance();
    advance();
    settle();
    chk("rst_req",  32'(ibus_req),  32'd0);
    chk("rst_addr", ibus_addr,      32'd0);
    chk("rst_inst", inst_o,         NOP);
    chk("rst_tmo",  32'(timeout_o), 32'd0);
    advance();

    // Zero-wait fetch stream
    rst = 0; ce = 1; ibus_rdata = 32'h2401_0001;
    for (int i = 0; i < 6; i++) begin
      ibus_ack = m_busy;
      settle();
      if (i % 2 == 1) begin
        chk("t1_addr",  ibus_addr,        32'((i / 2) * 4));
        chk("t1_inst",  inst_o,           32'h2401_0001);
        chk("t1_stall", 32'(stallreq_if), 32'd0);
      end else begin
        chk("t1_idle_req", 32'(ibus_req), 32'd0);
      end
      advance();
    end

    // Three wait states
    pc = 32'h10;
    for (int j = 0; j < 5; j++) begin
      ibus_ack = (j == 4);
      ibus_rdata = 32'hAABB_0010;
      settle();
      if (j >= 1) chk("t2_addr", ibus_addr, 32'h10);
      if (j < 4) begin
        chk("t2_stall", 32'(stallreq_if), 32'd1);
        chk("t2_inst",  inst_o,           NOP);
      end else begin
        chk("t2_ack_inst",  inst_o,           32'hAABB_0010);
        chk("t2_ack_stall", 32'(stallreq_if), 32'd0);
      end
      advance();
    end

    // Ack under IF/ID stall, held four cycles
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      stall = (k >= 1 && k <= 4) ? 6'b000011 : 6'b000000;
      ibus_ack = m_busy && (k == 1);
      ibus_rdata = (k == 1) ? 32'h8C22_0004 : $urandom;
      settle();
      if (inst_o == 32'h8C22_0004 && !stallreq_if && !stall[1]) cnt++;
      if (k >= 2 && k <= 5) begin
        chk("t3_inst",  inst_o,           32'h8C22_0004);
        chk("t3_req",   32'(ibus_req),    32'd0);
        chk("t3_stall", 32'(stallreq_if), 32'd0);
      end
      advance();
    end
    chk("t3_deliver_once", 32'(cnt), 32'd1);
    stall = '0;

    // Flush during wait, ack three cycles later
    for (int m = 0; m < 7; m++) begin
      flush = (m == 1);
      ibus_ack = m_busy && (m == 4 || m == 6);
      ibus_rdata = $urandom;
      settle();
      if (m >= 2 && m <= 4) begin
        chk("t4_req",   32'(ibus_req),    32'd1);
        chk("t4_inst",  inst_o,           NOP);
        chk("t4_stall", 32'(stallreq_if), 32'd1);
      end
      if (m == 5) chk("t4_idle_req", 32'(ibus_req), 32'd0);
      if (m == 6) chk("t4_new_addr", ibus_addr, 32'h180);
      advance();
    end
    flush = 0;

    // Flush coincident with ack
    for (int n = 0; n < 3; n++) begin
      flush = (n == 1);
      ibus_ack = m_busy && (n == 1);
      ibus_rdata = 32'hDEAD_BEEF;
      settle();
      if (n == 1) chk("t5_inst", inst_o, NOP);
      if (n == 2) chk("t5_req", 32'(ibus_req), 32'd0);
      advance();
    end
    flush = 0;

    // Timeout with no ack, then reset mid-request
    cnt = 0;
    ibus_ack = 0;
    for (int t = 0; t < 11; t++) begin
      settle();
      if (timeout_o) cnt++;
      chk("t6_tmo", 32'(timeout_o), 32'(t == 8));
      chk("t6_req", 32'(ibus_req),  32'(t <= 8 || t == 10));
      advance();
    end
    chk("t6_pulses", 32'(cnt), 32'd1);
    rst = 1;
    settle();
    chk("t6_rst_cycle_req", 32'(ibus_req), 32'd1);
    advance();
    rst = 0; ce = 0;
    settle();
    chk("t6_post_rst_req",  32'(ibus_req), 32'd0);
    chk("t6_post_rst_inst", inst_o,        NOP);
    advance();

    // Randomized traffic
    for (int r = 0; r < 600; r++) begin
      rst = ($urandom_range(0, 149) == 0);
      ce = ($urandom_range(0, 15) != 0);
      stall[1] = ($urandom_range(0, 3) == 0);
      stall[0] = stall[1] | ($urandom_range(0, 7) == 0);
      stall[5:2] = 4'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      ibus_ack = m_busy && ($urandom_range(0, 2) == 0);
      ibus_rdata = $urandom;
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
